// File: rtl/serial_magnitude_comparator_if.sv
// rtl/serial_magnitude_comparator_if.sv - request/result bundle for the bit-serial magnitude comparator
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    localparam int BW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;
    logic [BW-1:0]    bits_used;

    modport master (
        output start, a, b,
        input  busy, done, lt, gt, eq, bits_used
    );

    modport slave (
        input  start, a, b,
        output busy, done, lt, gt, eq, bits_used
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial MSB-first lt/gt/eq comparator; SERIAL_COMP_SIGNED_EN selects two's complement
module serial_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  cmp
);
    localparam int IW = $clog2(WIDTH);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             diff_q;
    logic             res_lt_q;
    logic             res_gt_q;
    logic [BW-1:0]    cnt;
    logic             lt_q;
    logic             gt_q;
    logic             eq_q;
    logic [BW-1:0]    bits_q;

    logic bit_a, bit_b, cur_lt, cur_gt, new_lt, new_gt, found, last;

    always_comb begin
        bit_a = a_q[idx];
        bit_b = b_q[idx];
`ifdef SERIAL_COMP_SIGNED_EN
        // Sign bit: a set bit means a negative value, so the sense flips
        if (idx == MSB_IDX) begin
            cur_gt = ~bit_a & bit_b;
            cur_lt = bit_a & ~bit_b;
        end else begin
            cur_gt = bit_a & ~bit_b;
            cur_lt = ~bit_a & bit_b;
        end
`else
        cur_gt = bit_a & ~bit_b;
        cur_lt = ~bit_a & bit_b;
`endif
        new_lt = diff_q ? res_lt_q : cur_lt;
        new_gt = diff_q ? res_gt_q : cur_gt;
        found  = diff_q | cur_lt | cur_gt;
        last   = (found && EARLY_EXIT) || (idx == '0);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmp.start) state_next = COMPARE;
            COMPARE: if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            diff_q   <= 1'b0;
            res_lt_q <= 1'b0;
            res_gt_q <= 1'b0;
            cnt      <= '0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            bits_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmp.start) begin
                        a_q      <= cmp.a;
                        b_q      <= cmp.b;
                        idx      <= MSB_IDX;
                        diff_q   <= 1'b0;
                        res_lt_q <= 1'b0;
                        res_gt_q <= 1'b0;
                        cnt      <= '0;
                    end
                end
                COMPARE: begin
                    cnt      <= cnt + BW'(1);
                    diff_q   <= found;
                    res_lt_q <= new_lt;
                    res_gt_q <= new_gt;
                    // Visible results change only as DONE is entered
                    if (last) begin
                        lt_q   <= new_lt;
                        gt_q   <= new_gt;
                        eq_q   <= ~(new_lt | new_gt);
                        bits_q <= cnt + BW'(1);
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmp.busy      = (state == COMPARE);
    assign cmp.done      = (state == DONE);
    assign cmp.lt        = lt_q;
    assign cmp.gt        = gt_q;
    assign cmp.eq        = eq_q;
    assign cmp.bits_used = bits_q;
endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Parametrised, bit-serial magnitude comparator. It is the multi-bit successor of the team's 1-bit lt/gt/eq comparator.
- Captures two WIDTH-bit operands on a start request.
- Applies a 1-bit compare per clock, MSB first, with optional early exit on the first differing bit.
- Reports lt/gt/eq with a one-cycle done pulse.
- Intended for area-constrained datapaths where a parallel comparator is too large.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- EARLY_EXIT, 1, 1 = finish on the first differing bit; 0 = always examine all WIDTH bits (fixed latency).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- busy  output  1  high while in COMPARE.
- done  output  1  one-cycle pulse when the result becomes valid.
- lt  output  1  A < B (registered, held).
- gt  output  1  A > B (registered, held).
- eq  output  1  A == B (registered, held).
- bits_used  output  $clog2(WIDTH+1)  number of bits examined for the last result.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; busy, done, lt, gt, eq = 0; bits_used = 0; operand registers and index cleared. Reset dominates every other input.
- Reset mid-compare aborts the operation: no done pulse, outputs return to 0.
- States: IDLE, COMPARE, DONE.
- IDLE: start=1 captures a/b into internal registers, sets idx=WIDTH-1, clears the first-difference flag, and moves to COMPARE. Outputs are not altered on this edge.
- COMPARE, one bit per cycle, at position idx:
  - A[idx]=1, B[idx]=0, no earlier difference: record gt.
  - A[idx]=0, B[idx]=1, no earlier difference: record lt.
  - Bits after the first difference never change the recorded result.
  - bits_used increments each COMPARE cycle.
  - Leave COMPARE when a difference is found and EARLY_EXIT=1, or when idx==0. Otherwise decrement idx.
  - If idx==0 with no difference recorded: eq.
- DONE, one cycle:
  - lt/gt/eq load the new result; exactly one is 1.
  - done=1; busy=0.
  - Return to IDLE next cycle.
  - lt/gt/eq/bits_used hold until the next DONE.
- busy=1 for every cycle spent in COMPARE. start while busy or in DONE is ignored; it is not queued.
- Latency, counted from the start-accept edge to the done=1 cycle:
  - EARLY_EXIT=0: always WIDTH+1 cycles.
  - EARLY_EXIT=1: (WIDTH-p)+1 cycles, where p is the highest differing bit index. Equal operands take WIDTH+1 cycles.
- Back-to-back: start may be asserted in the cycle done=1. It is accepted on the following IDLE cycle, so the minimum issue interval is latency+1.
- Operands a/b may change freely after capture.

Optional Feature:
- Macro: SERIAL_COMP_SIGNED_EN.
- Defined: operands are two's complement. At the MSB only (idx==WIDTH-1) the bit sense is inverted: A[MSB]=1, B[MSB]=0 gives lt; A[MSB]=0, B[MSB]=1 gives gt. Lower bits compare as unsigned.
- Not defined: unsigned compare on all bits.
- Latency and handshake are identical in both builds.

Test Plan:
- Equal operands, WIDTH=8, EARLY_EXIT=1: a=0x5A, b=0x5A, start -> done 9 cycles after accept; eq=1, lt=gt=0, bits_used=8; busy high 8 cycles.
- MSB difference: a=0x80, b=0x7F.
  - Unsigned build -> gt=1, bits_used=1, done 2 cycles after accept.
  - SERIAL_COMP_SIGNED_EN build -> lt=1, same latency.
- LSB difference: a=0x12, b=0x13 -> lt=1, bits_used=8.
  - EARLY_EXIT=0 rerun of a=0x80, b=0x7F -> gt=1, bits_used=8, done after 9 cycles.
- Busy protection: start held high through a 0x80 vs 0x7F compare, with a/b changed to 0x00/0xFF mid-operation -> first result gt=1. The second start is accepted only after IDLE and yields lt=1.
- Reset mid-operation: start a=0x01, b=0x01, assert rst on the 3rd COMPARE cycle -> no done pulse; all outputs 0 the next cycle; a fresh start then completes normally with eq=1.
